// File: rtl/dw01_sub_pipe_8.sv
// dw01_sub_pipe_8: registered two-stage unsigned subtractor, DIFF = A - B - BI.
// Stage 1 resolves the low LO_WIDTH bits and keeps the high operand bits.
// Stage 2 resolves the high bits using the registered low borrow. The borrow
// chain in any one cycle therefore spans at most max(LO_WIDTH, WIDTH-LO_WIDTH) bits.
//
// Ports
//   CLK        rising-edge clock
//   RST        asynchronous reset, active-high
//   IN_VALID   A/B/BI are valid
//   IN_READY   block accepts operands this cycle (combinational from OUT_READY)
//   A, B       minuend / subtrahend, unsigned, WIDTH bits
//   BI         borrow-in, subtracted at bit 0
//   OUT_VALID  DIFF/BO hold a result
//   OUT_READY  consumer takes the result this cycle
//   DIFF       (A - B - BI) mod 2**WIDTH
//   BO         borrow-out, 1 iff A < B + BI
//
// Only WIDTH=8 is supported in this revision; LO_WIDTH must satisfy
// 1 <= LO_WIDTH < WIDTH.
module dw01_sub_pipe_8 #(
  parameter int WIDTH    = 8,
  parameter int LO_WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             BI,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] DIFF,
  output logic             BO
);

  localparam int HI_WIDTH = WIDTH - LO_WIDTH;

  logic                s1_valid;
  logic [LO_WIDTH-1:0] d_lo;
  logic                b_lo;
  logic [HI_WIDTH-1:0] a_hi;
  logic [HI_WIDTH-1:0] b_hi;

  logic                in_xfer;
  logic                advance;
  logic [LO_WIDTH:0]   lo_full;
  logic [HI_WIDTH:0]   hi_full;

  // Stage 2 is free when it is empty or being drained this cycle.
  assign advance  = s1_valid && (!OUT_VALID || OUT_READY);
  assign IN_READY = !s1_valid || !OUT_VALID || OUT_READY;
  assign in_xfer  = IN_VALID && IN_READY;

  // Zero-extended subtract: the extra top bit is the borrow out of the field,
  // because a negative two's-complement result sets it.
  assign lo_full = {1'b0, A[LO_WIDTH-1:0]} - {1'b0, B[LO_WIDTH-1:0]}
                 - {{LO_WIDTH{1'b0}}, BI};
  assign hi_full = {1'b0, a_hi} - {1'b0, b_hi} - {{HI_WIDTH{1'b0}}, b_lo};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_valid <= 1'b0;
    end else if (in_xfer) begin
      s1_valid <= 1'b1;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  // Operand registers only load on an accepted input.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      d_lo <= '0;
      b_lo <= 1'b0;
      a_hi <= '0;
      b_hi <= '0;
    end else if (in_xfer) begin
      d_lo <= lo_full[LO_WIDTH-1:0];
      b_lo <= lo_full[LO_WIDTH];
      a_hi <= A[WIDTH-1:LO_WIDTH];
      b_hi <= B[WIDTH-1:LO_WIDTH];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OUT_VALID <= 1'b0;
    end else if (advance) begin
      OUT_VALID <= 1'b1;
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

  // Result registers only load on advance, so they hold under backpressure.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DIFF <= '0;
      BO   <= 1'b0;
    end else if (advance) begin
      DIFF <= {hi_full[HI_WIDTH-1:0], d_lo};
      BO   <= hi_full[HI_WIDTH];
    end
  end

endmodule

// File: tb/tb_dw01_sub_pipe_8.sv
module tb_dw01_sub_pipe_8;

  logic       CLK;
  logic       RST;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] A;
  logic [7:0] B;
  logic       BI;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [7:0] DIFF;
  logic       BO;

  dw01_sub_pipe_8 dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .BI(BI),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .DIFF(DIFF), .BO(BO)
  );

  typedef struct {
    logic [7:0] d;
    logic       bo;
    int         acc;
    bit         has_lit;
    logic [7:0] lit_d;
    logic       lit_bo;
  } ent_t;

  ent_t       q[$];
  int         vectors;
  int         miscompares;
  int         cyc;
  int         stalls;
  bit         lit_has;
  logic [7:0] lit_d;
  logic       lit_bo;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: plain integer subtraction; negative result means borrow-out.
  function automatic ent_t model(input logic [7:0] a, input logic [7:0] b, input logic bi);
    ent_t e;
    int   r;
    r = int'(a) - int'(b) - int'(bi);
    e.d  = r[7:0];
    e.bo = (r < 0);
    e.acc = 0;
    e.has_lit = 1'b0;
    e.lit_d = 8'h00;
    e.lit_bo = 1'b0;
    return e;
  endfunction

  // Compare process: the queue holds every accepted, not yet delivered result.
  always @(negedge CLK) begin
    int   n;
    logic exp_ov;
    logic exp_ir;
    ent_t e;
    if (RST) begin
      q.delete();
      chk("rst_out_valid", {8'h00, OUT_VALID}, 9'h000);
      chk("rst_diff_bo", {BO, DIFF}, 9'h000);
    end else begin
      n = q.size();
      // A lone result accepted on the last edge is still in stage 1.
      exp_ov = (n == 2) || (n == 1 && q[0].acc != cyc);
      exp_ir = !(n == 2 && !OUT_READY);
      chk("out_valid", {8'h00, OUT_VALID}, {8'h00, exp_ov});
      chk("in_ready", {8'h00, IN_READY}, {8'h00, exp_ir});
      if (OUT_VALID === 1'b1 && n > 0) begin
        chk("model_diff_bo", {BO, DIFF}, {q[0].bo, q[0].d});
        if (q[0].has_lit)
          chk("literal_diff_bo", {BO, DIFF}, {q[0].lit_bo, q[0].lit_d});
        if (OUT_READY) void'(q.pop_front());
      end
      if (IN_VALID && IN_READY) begin
        e = model(A, B, BI);
        e.acc = cyc + 1;
        e.has_lit = lit_has;
        e.lit_d = lit_d;
        e.lit_bo = lit_bo;
        q.push_back(e);
        vectors++;
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic bi,
                      input bit has, input logic [7:0] ld, input logic lb);
    logic rdy;
    int   n;
    A = a; B = b; BI = bi; IN_VALID = 1'b1;
    lit_has = has; lit_d = ld; lit_bo = lb;
    n = 0;
    forever begin
      @(negedge CLK);
      rdy = IN_READY;
      @(posedge CLK);
      #1;
      if (rdy) break;
      stalls++;
      n++;
      if (n > 50) begin
        miscompares++;
        $display("FAIL send_timeout: IN_READY stayed 0, expected 1 within 50 cycles");
        break;
      end
    end
  endtask

  task automatic idle();
    IN_VALID = 1'b0;
    lit_has = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    for (n = 0; n < 20; n++) begin
      if (q.size() == 0 && OUT_VALID === 1'b0) break;
      @(posedge CLK);
      #1;
    end
    if (n == 20) begin
      miscompares++;
      $display("FAIL drain_timeout: pipe not empty, got %0d pending, expected 0", q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; stalls = 0;
    RST = 1'b1; IN_VALID = 1'b0; A = 8'h00; B = 8'h00; BI = 1'b0;
    OUT_READY = 1'b0; lit_has = 1'b0; lit_d = 8'h00; lit_bo = 1'b0;
    #2;
    chk("reset_out_valid", {8'h00, OUT_VALID}, 9'h000);
    chk("reset_diff_bo", {BO, DIFF}, 9'h000);
    #10 RST = 1'b0;
    #1;
    chk("reset_in_ready", {8'h00, IN_READY}, 9'h001);
    @(posedge CLK); #1;
    OUT_READY = 1'b1;

    // Basic subtract with latency pinned by hand.
    send(8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b0);
    idle();
    chk("latency_edge1", {8'h00, OUT_VALID}, 9'h000);
    @(posedge CLK); #1;
    chk("latency_edge2", {8'h00, OUT_VALID}, 9'h001);
    chk("basic_result", {BO, DIFF}, 9'h002);
    wait_empty();

    // Nibble boundary, wrap-around, borrow-in corners.
    send(8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b0);
    send(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1);
    send(8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1);
    send(8'h80, 8'h00, 1'b1, 1'b1, 8'h7F, 1'b0);
    send(8'h42, 8'h42, 1'b1, 1'b1, 8'hFF, 1'b1);
    send(8'h00, 8'hFF, 1'b0, 1'b1, 8'h01, 1'b1);
    idle();
    wait_empty();

    // Streaming: one accept per cycle with no stall.
    stalls = 0;
    for (int i = 0; i < 256; i++)
      send(8'(i), 8'h37, i[0], 1'b0, 8'h00, 1'b0);
    idle();
    chk("stream_stalls", 9'(stalls), 9'h000);
    wait_empty();

    // Backpressure: two results fill the pipe, third waits.
    OUT_READY = 1'b0;
    send(8'h09, 8'h01, 1'b0, 1'b1, 8'h08, 1'b0);
    send(8'h09, 8'h02, 1'b0, 1'b1, 8'h07, 1'b0);
    A = 8'h09; B = 8'h03; BI = 1'b0; IN_VALID = 1'b1;
    lit_has = 1'b1; lit_d = 8'h06; lit_bo = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      chk("bp_in_ready", {8'h00, IN_READY}, 9'h000);
      chk("bp_hold_diff", {BO, DIFF}, 9'h008);
    end
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    send(8'h09, 8'h03, 1'b0, 1'b1, 8'h06, 1'b0);
    idle();
    wait_empty();

    // Reset mid-flight: both stages full, reset between edges.
    send(8'h30, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0);
    send(8'h40, 8'h02, 1'b0, 1'b0, 8'h00, 1'b0);
    idle();
    #1 RST = 1'b1;
    #1;
    chk("midrst_out_valid", {8'h00, OUT_VALID}, 9'h000);
    chk("midrst_diff_bo", {BO, DIFF}, 9'h000);
    @(negedge CLK);
    #2 RST = 1'b0;
    @(posedge CLK); #1;
    send(8'h20, 8'h10, 1'b0, 1'b1, 8'h10, 1'b0);
    idle();
    wait_empty();

    repeat (2) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dw01_sub_pipe_8.md
Name: dw01_sub_pipe_8

Overview:
- Registered two-stage 8-bit subtractor with borrow-in/borrow-out and a valid/ready handshake on both sides.
- It is the decrement/subtract counterpart of the team's DW01 add macros, used where a datapath must go down instead of up: pointer rewind, credit return, countdown operands.
- Low nibble is computed in stage 1 and high nibble in stage 2, so the borrow chain per cycle is 4 bits long.

Parameters:
- WIDTH, 8: operand and result width. Only 8 is supported in this revision.
- LO_WIDTH, 4: number of bits resolved in stage 1. Stage 2 resolves WIDTH-LO_WIDTH bits. Must satisfy 1 <= LO_WIDTH < WIDTH.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous reset, active-high.
- IN_VALID  input  1  operands A, B, BI are valid.
- IN_READY  output  1  block accepts operands this cycle.
- A  input  8  minuend, unsigned.
- B  input  8  subtrahend, unsigned.
- BI  input  1  borrow-in, subtracted at bit 0.
- OUT_VALID  output  1  DIFF/BO hold a result.
- OUT_READY  input  1  consumer takes the result this cycle.
- DIFF  output  8  (A - B - BI) mod 256.
- BO  output  1  borrow-out: 1 iff A < B + BI (unsigned, 9-bit compare).

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous and active-high.
- Reset values: s1_valid=0, OUT_VALID=0, DIFF=0x00, BO=0, all stage-1 data registers 0. IN_READY=1 while RST is deasserted and the pipe is empty.
- Transfers: an input transfer occurs on a CLK edge where IN_VALID && IN_READY. An output transfer occurs on a CLK edge where OUT_VALID && OUT_READY.
- Stage 1 (on input transfer):
  - Register d_lo = A[3:0] - B[3:0] - BI (4 bits) and b_lo = borrow out of bit 3.
  - Register A[7:4] and B[7:4] unchanged.
  - Set s1_valid=1.
- Stage 2 (on advance):
  - DIFF[3:0] <= d_lo.
  - DIFF[7:4] <= A_hi - B_hi - b_lo.
  - BO <= borrow out of bit 7.
  - OUT_VALID <= 1.
- Advance rule: stage 2 loads when s1_valid && (!OUT_VALID || OUT_READY).
- Input ready: IN_READY = !s1_valid || !OUT_VALID || OUT_READY. This is combinational from OUT_READY; there is no combinational path from IN_VALID to IN_READY.
- Stage-1 clear: s1_valid clears when stage 2 advances and there is no new input transfer in the same cycle.
- Output clear: OUT_VALID clears on an output transfer when stage 1 is not advancing in the same cycle.
- Latency: 2 CLK edges from input transfer to OUT_VALID, with no backpressure.
- Throughput: 1 result per cycle sustained while OUT_READY=1.
- Backpressure: with OUT_READY=0 the pipe holds exactly 2 results. IN_READY drops once both stages are full. DIFF and BO stay stable while OUT_VALID && !OUT_READY.
- Ordering: results leave strictly in acceptance order; nothing is dropped or duplicated.
- Simultaneous events:
  - Input transfer and stage advance in the same cycle: stage 1 reloads with the new operands.
  - Output transfer and stage advance in the same cycle: OUT_VALID stays 1 and DIFF/BO take the new value.
- Data-register gating: data registers load only on their transfer/advance enable. They do not toggle when the valid is low (power guidance).
- Wrap-around: arithmetic is modulo 256. BO reports the underflow. BI=1 with A=B yields 0xFF with BO=1.
- Reset mid-operation: asserting RST clears both valids immediately, asynchronously. In-flight operands are discarded. No output transfer is reported after RST rises.
- Handshake obligations: no X on DIFF/BO while OUT_VALID=1. IN_VALID may drop without a transfer; no stickiness is required of the source.

Test Plan:
- Basic subtract: A=0x05, B=0x03, BI=0, OUT_READY=1 -> two edges later OUT_VALID=1, DIFF=0x02, BO=0.
- Nibble-boundary borrow: A=0x10, B=0x01, BI=0 -> DIFF=0x0F, BO=0. Also A=0x00, B=0x01 -> DIFF=0xFF, BO=1.
- Borrow-in and extreme values:
  - A=0xFF, B=0xFF, BI=1 -> DIFF=0xFF, BO=1.
  - A=0x80, B=0x00, BI=1 -> DIFF=0x7F, BO=0.
- Streaming: 256 back-to-back operands (A=i, B=0x37, BI=i[0]) with OUT_READY=1 -> one result per cycle, in order, each matching a reference model.
- Backpressure: send 0x09-0x01, 0x09-0x02, 0x09-0x03 with OUT_READY=0 for 4 cycles:
  - IN_READY=0 after 2 accepted; DIFF holds 0x08.
  - Release OUT_READY -> outputs 0x08, 0x07, 0x06 in order, then the pipe is empty.
- Reset mid-flight: accept 2 operands, assert RST between edges -> OUT_VALID=0, DIFF=0x00, BO=0 immediately. After release, the next operand 0x20-0x10 returns 0x10 with no stale result before it.
